seven_segment_reader: RTL and testbench
=======================================

Name: seven_segment_reader

Overview:
- Monitors a multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode enables) and recovers the per-digit value code.
- Output code uses the same 6-bit format that drives our display decoder: bits[3:0] = hex value, bit4 = contention "U", bit5 = high-impedance "H".
- Used in benches and on-chip self-check to read back what the display path actually shows, including for loopback against the display decoder.
- Emits one record per stable digit observation over a valid/ready interface.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines), >=1
- STABLE_CYCLES, 4, consecutive identical registered samples required before capture, >=1

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- seg_n  input  7  segment lines, active low, bit6..bit0 = g..a
- an_n  input  NUM_DIGITS  anode enables, active low
- out_valid  output  1  record available
- out_ready  input  1  consumer accepts record
- out_digit  output  max(1,$clog2(NUM_DIGITS))  index of the captured digit
- out_code  output  6  decoded code (format above)
- out_blank  output  1  pattern was all-off (7'b1111111); out_code=0
- out_error  output  1  pattern not in table and not blank; out_code=0
- overrun  output  1  sticky; a capture was dropped

Behaviour:
- Reset: out_valid=0, out_digit=0, out_code=0, out_blank=0, out_error=0, overrun=0. Input registers cleared to an_n=all-ones, seg_n=all-ones. Stability counter=0. State=IDLE. Reset mid-record discards the held record.
- Input stage: seg_n and an_n are registered once (sample register S). The previous S is held in P.
- Stability counter:
  - If S!=P, or S.an_n does not have exactly one low bit, cnt=0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- FSM:
  - IDLE: exactly-one-low an_n -> SETTLE; otherwise stay.
  - SETTLE: cnt reaches STABLE_CYCLES-1 while still stable -> capture, go to HELD.
  - SETTLE, instability or invalid an_n: return to IDLE/SETTLE per new S; cnt=0.
  - HELD: no further capture until S changes; then IDLE/SETTLE.
  - Exactly one capture per stable period.
- Latency: a value driven before edge 0 and then held yields out_valid=1 after edge STABLE_CYCLES+1 (edge 5 at default).
- Decode table (seg_n -> code):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0010000->9, 0001000->A, 0000011->B
  - 1000110->C, 0100001->D, 0000110->E, 0001110->F
  - 1000001->6'b010000 (U)
  - 0001001->6'b100000 (H)
  - 1111111->blank
  - anything else->error
- out_digit is the index of the low an_n bit.
- Output buffer (single entry):
  - Capture with out_valid=0, or out_valid&&out_ready in the same cycle: load the record; out_valid=1 next edge.
  - out_valid&&out_ready with no capture: out_valid=0 next edge.
  - Capture while out_valid=1 and out_ready=0: new record dropped, held record unchanged, overrun=1 (cleared only by reset).
- Outputs are stable while out_valid=1 and out_ready=0.
- Zero or multiple anodes low is never captured and is not an error.

Test Plan:
- Reset, then an_n=4'b1110, seg_n=7'b0010010 held 10 cycles, out_ready=1 -> exactly one record, 5 edges after first sample edge: digit=0, code=6'h05, blank=0, error=0.
- Scan digits 0..3 with patterns 1111001, 0001000, 1000001, 0001001, each held 6 cycles -> records (0,6'h01), (1,6'h0A), (2,6'h10), (3,6'h20), in order.
- seg_n toggles between 0 and 8 patterns every 2 cycles with STABLE_CYCLES=4 -> no out_valid ever.
- an_n=4'b1100 (two digits active) held 10 cycles -> no record. Then an_n=4'b1011 with seg_n=7'b1111111 -> digit=2, blank=1, code=0. Then seg_n=7'b1010101 -> record with error=1.
- out_ready=0 and two stable captures -> first record held unchanged, overrun=1. out_ready=1 -> record accepted, out_valid=0.
- Assert reset while out_valid=1 -> all outputs 0 next edge, including overrun. Stable input after reset -> capture within STABLE_CYCLES+1 edges.

Source files
------------

// File: rtl/seven_segment_reader.sv
// seven_segment_reader
// Watches a multiplexed active-low seven-segment bus and recovers the value
// shown on each digit. A digit is reported once it has been shown unchanged,
// with exactly one anode active, for STABLE_CYCLES registered samples.
// Records leave through a single-entry valid/ready buffer. A record that
// arrives while the buffer is still full is dropped, and the drop is flagged
// on the sticky overrun output.

module seven_segment_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_n,
  input  logic [NUM_DIGITS-1:0] an_n,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_digit,
  output logic [5:0]            out_code,
  output logic                  out_blank,
  output logic                  out_error,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX     = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAPTURE = CW'(STABLE_CYCLES - 1);

  // True when exactly one anode line is low.
  function automatic logic one_low(input logic [NUM_DIGITS-1:0] an);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) begin
        if (seen) begin
          multi = 1'b1;
        end
        seen = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

  // Index of the low anode line; only meaningful when one_low() holds.
  function automatic logic [DW-1:0] low_index(input logic [NUM_DIGITS-1:0] an);
    logic [DW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) begin
        idx = DW'(i);
      end
    end
    return idx;
  endfunction

  // Segment pattern to {blank, error, code[5:0]}.
  function automatic logic [7:0] decode(input logic [6:0] seg);
    logic [7:0] r;
    case (seg)
      7'b1000000: r = 8'h00;
      7'b1111001: r = 8'h01;
      7'b0100100: r = 8'h02;
      7'b0110000: r = 8'h03;
      7'b0011001: r = 8'h04;
      7'b0010010: r = 8'h05;
      7'b0000010: r = 8'h06;
      7'b1111000: r = 8'h07;
      7'b0000000: r = 8'h08;
      7'b0010000: r = 8'h09;
      7'b0001000: r = 8'h0A;
      7'b0000011: r = 8'h0B;
      7'b1000110: r = 8'h0C;
      7'b0100001: r = 8'h0D;
      7'b0000110: r = 8'h0E;
      7'b0001110: r = 8'h0F;
      7'b1000001: r = 8'h10;   // contention "U"
      7'b0001001: r = 8'h20;   // high-impedance "H"
      7'b1111111: r = 8'h80;   // blank
      default:    r = 8'h40;   // unknown pattern
    endcase
    return r;
  endfunction

  logic [6:0]            seg_smp_r;
  logic [NUM_DIGITS-1:0] an_smp_r;
  logic [6:0]            seg_prev_r;
  logic [NUM_DIGITS-1:0] an_prev_r;
  logic [CW-1:0]         cnt_r;
  state_t                state_r;
  state_t                state_next_s;
  logic                  an_ok_s;
  logic                  stable_s;
  logic                  capture_s;
  logic [7:0]            dec_s;

  assign an_ok_s  = one_low(an_smp_r);
  assign stable_s = an_ok_s && (seg_smp_r == seg_prev_r) && (an_smp_r == an_prev_r);
  assign dec_s    = decode(seg_smp_r);

  // Sample the bus once (S) and keep the previous sample (P).
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_smp_r  <= 7'h7F;
      an_smp_r   <= '1;
      seg_prev_r <= 7'h7F;
      an_prev_r  <= '1;
    end else begin
      seg_smp_r  <= seg_n;
      an_smp_r   <= an_n;
      seg_prev_r <= seg_smp_r;
      an_prev_r  <= an_smp_r;
    end
  end

  // Count consecutive identical valid samples, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (!stable_s) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; any instability re-arms from the new sample.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (an_ok_s) begin
          state_next_s = SETTLE;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETTLE: begin
        if (stable_s && (cnt_r == CNT_CAPTURE)) begin
          state_next_s = HELD;
        end else if (!stable_s) begin
          state_next_s = an_ok_s ? SETTLE : IDLE;
        end else begin
          state_next_s = SETTLE;
        end
      end
      HELD: begin
        if (!stable_s) begin
          state_next_s = an_ok_s ? SETTLE : IDLE;
        end else begin
          state_next_s = HELD;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output: one capture pulse per stable period.
  always_comb begin
    capture_s = 1'b0;
    if ((state_r == SETTLE) && stable_s && (cnt_r == CNT_CAPTURE)) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Single-entry output buffer with sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_digit <= '0;
      out_code  <= 6'h00;
      out_blank <= 1'b0;
      out_error <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (capture_s && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_digit <= low_index(an_smp_r);
        out_code  <= dec_s[5:0];
        out_error <= dec_s[6];
        out_blank <= dec_s[7];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (capture_s && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: table-driven digit vectors with a
// scoreboard of expected records, plus hand sequences for latency,
// instability, back-pressure/overrun and reset.

module tb_seven_segment_reader;

  logic       clk;
  logic       reset;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_digit;
  logic [5:0] out_code;
  logic       out_blank;
  logic       out_error;
  logic       overrun;

  seven_segment_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .an_n(an_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_code(out_code), .out_blank(out_blank), .out_error(out_error),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] digit;
    logic [5:0] code;
    logic       blank;
    logic       error;
  } rec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [7:0] hold;
    logic       rec;
    rec_t       exp;
  } vec_t;

  rec_t sb[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    an_n  = v.an;
    seg_n = v.seg;
    if (v.rec) sb.push_back(v.exp);
    repeat (int'(v.hold)) step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},   out_valid, 0);
    check({tag, "_digit"},   out_digit, 0);
    check({tag, "_code"},    out_code, 0);
    check({tag, "_blank"},   out_blank, 0);
    check({tag, "_error"},   out_error, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  // Scoreboard: compare each accepted record against the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_record: got digit=%0d code=%h, expected no record",
                 out_digit, out_code);
      end else begin
        rec_t e;
        e = sb.pop_front();
        check("rec_digit", out_digit, e.digit);
        check("rec_code",  out_code,  e.code);
        check("rec_blank", out_blank, e.blank);
        check("rec_error", out_error, e.error);
      end
    end
  end

  function automatic vec_t mk(input logic [3:0] an, input logic [6:0] seg,
                              input logic rec, input logic [1:0] d,
                              input logic [5:0] c, input logic b, input logic er,
                              input logic [7:0] hold);
    vec_t v;
    v.an = an; v.seg = seg; v.hold = hold; v.rec = rec;
    v.exp.digit = d; v.exp.code = c; v.exp.blank = b; v.exp.error = er;
    return v;
  endfunction

  initial begin
    logic [6:0] hex_pat [16];
    int first;
    int nvalid;

    hex_pat[0]  = 7'b1000000; hex_pat[1]  = 7'b1111001;
    hex_pat[2]  = 7'b0100100; hex_pat[3]  = 7'b0110000;
    hex_pat[4]  = 7'b0011001; hex_pat[5]  = 7'b0010010;
    hex_pat[6]  = 7'b0000010; hex_pat[7]  = 7'b1111000;
    hex_pat[8]  = 7'b0000000; hex_pat[9]  = 7'b0010000;
    hex_pat[10] = 7'b0001000; hex_pat[11] = 7'b0000011;
    hex_pat[12] = 7'b1000110; hex_pat[13] = 7'b0100001;
    hex_pat[14] = 7'b0000110; hex_pat[15] = 7'b0001110;

    // Digit scan, multiple-anode, blank, error, then full hex sweep on digit 1.
    vecs.push_back(mk(4'b1110, 7'b1111001, 1'b1, 2'd0, 6'h01, 1'b0, 1'b0, 8'd6));
    vecs.push_back(mk(4'b1101, 7'b0001000, 1'b1, 2'd1, 6'h0A, 1'b0, 1'b0, 8'd6));
    vecs.push_back(mk(4'b1011, 7'b1000001, 1'b1, 2'd2, 6'h10, 1'b0, 1'b0, 8'd6));
    vecs.push_back(mk(4'b0111, 7'b0001001, 1'b1, 2'd3, 6'h20, 1'b0, 1'b0, 8'd6));
    vecs.push_back(mk(4'b1100, 7'b0010010, 1'b0, 2'd0, 6'h00, 1'b0, 1'b0, 8'd10));
    vecs.push_back(mk(4'b1011, 7'b1111111, 1'b1, 2'd2, 6'h00, 1'b1, 1'b0, 8'd6));
    vecs.push_back(mk(4'b1011, 7'b1010101, 1'b1, 2'd2, 6'h00, 1'b0, 1'b1, 8'd6));
    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mk(4'b1101, hex_pat[i], 1'b1, 2'd1, 6'(i), 1'b0, 1'b0, 8'd6));
    end

    // Reset state.
    reset = 1'b1; an_n = 4'hF; seg_n = 7'h7F; out_ready = 1'b1;
    repeat (3) step();
    check_zero_outputs("reset");
    reset = 1'b0;
    step();

    // Latency: first record exactly 5 edges after the first sample edge.
    an_n = 4'b1110; seg_n = 7'b0010010;
    sb.push_back('{digit: 2'd0, code: 6'h05, blank: 1'b0, error: 1'b0});
    first = -1; nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid) begin
        if (first < 0) first = k;
        nvalid++;
      end
    end
    check("latency_edges", first, 5);
    check("single_record", nvalid, 1);

    // Table vectors.
    foreach (vecs[i]) run_vec(vecs[i]);
    repeat (3) step();
    check("table_sb_drained", sb.size(), 0);

    // Toggling pattern never settles.
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      an_n = 4'b1110;
      seg_n = (i % 2 == 1) ? 7'b0000000 : 7'b1000000;
      repeat (2) begin
        step();
        if (out_valid) nvalid++;
      end
    end
    check("toggle_no_valid", nvalid, 0);

    // Back-pressure: second capture dropped, held record unchanged.
    out_ready = 1'b0;
    run_vec(mk(4'b1110, 7'b0010010, 1'b1, 2'd0, 6'h05, 1'b0, 1'b0, 8'd6));
    check("bp_valid", out_valid, 1);
    check("bp_overrun_before", overrun, 0);
    an_n = 4'b1101; seg_n = 7'b0010000;
    for (int k = 0; k < 6; k++) begin
      step();
      check("bp_hold_digit", out_digit, 0);
      check("bp_hold_code", out_code, 6'h05);
    end
    check("bp_overrun", overrun, 1);
    check("bp_valid_held", out_valid, 1);
    out_ready = 1'b1;
    step();
    check("bp_accepted", out_valid, 0);
    check("bp_overrun_sticky", overrun, 1);
    check("bp_sb_drained", sb.size(), 0);

    // Reset while a record is held.
    out_ready = 1'b0;
    run_vec(mk(4'b1011, 7'b1111000, 1'b1, 2'd2, 6'h07, 1'b0, 1'b0, 8'd6));
    check("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    sb.delete();
    an_n = 4'b0111; seg_n = 7'b0000010; out_ready = 1'b1;
    step();
    check_zero_outputs("midreset");
    reset = 1'b0;
    sb.push_back('{digit: 2'd3, code: 6'h06, blank: 1'b0, error: 1'b0});
    first = -1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid && first < 0) first = k;
    end
    check("post_reset_latency", first, 5);
    check("final_sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
